outpkt_cmp_result: RTL and testbench

// Builds CMP_RESULT output packets (application -> host), the counterpart of the input packet parser.

---
 rtl/outpkt_cmp_result.sv | 129 ++++++++++++
 tb/tb_outpkt_cmp_result.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outpkt_cmp_result.sv
// CMP_RESULT packet builder: pops one comparator result record and
// streams it as a 13-word checksummed packet into output_fifo.
module outpkt_cmp_result #(
    parameter logic [7:0] VERSION          = 8'd2,
    parameter logic [7:0] PKT_TYPE         = 8'hD4,
    parameter bit         DISABLE_CHECKSUM = 1'b0
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        res_empty,
    output logic        res_rd_en,
    input  logic [15:0] res_word_id,
    input  logic [31:0] res_gen_id,
    input  logic [15:0] res_hash_num,
    output logic [15:0] dout,
    output logic        wr_en,
    input  logic        full,
    output logic        idle,
    output logic [15:0] pkt_count
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [15:0] W0      = {PKT_TYPE, VERSION};
    localparam logic [15:0] BODY_LEN = 16'd8;
    localparam logic [3:0]  LAST_W  = 4'd12;

    state_t      state;
    logic [3:0]  wcnt;
    logic [3:0]  wnext;
    logic [15:0] pkt_id;
    logic [15:0] word_id_q;
    logic [31:0] gen_id_q;
    logic [15:0] hash_num_q;
    logic [31:0] hdr_csum;
    logic [31:0] body_csum;

    logic [31:0] hdr_sum_c;
    logic [31:0] body_sum_c;
    logic [31:0] hdr_csum_c;
    logic [31:0] body_csum_c;
    logic [15:0] nxt_word;

    always_comb begin
        res_rd_en = (state == IDLE) && !res_empty;
        idle      = (state == IDLE);
        wr_en     = (state == EMIT) && !full;
    end

    // reserved0/reserved1/len[23:16] are zero, so only the low halves add up
    always_comb begin
        hdr_sum_c  = {16'h0, W0} + {16'h0, BODY_LEN} + {16'h0, pkt_id};
        body_sum_c = {res_gen_id[15:0], res_word_id}
                   + {res_hash_num, res_gen_id[31:16]};
        hdr_csum_c  = DISABLE_CHECKSUM ? 32'h0 : ~hdr_sum_c;
        body_csum_c = DISABLE_CHECKSUM ? 32'h0 : ~body_sum_c;
    end

    assign wnext = wcnt + 4'd1;

    always_comb begin
        nxt_word = 16'h0;
        unique case (wnext)
            4'd1:    nxt_word = 16'h0;
            4'd2:    nxt_word = BODY_LEN;
            4'd3:    nxt_word = 16'h0;
            4'd4:    nxt_word = pkt_id;
            4'd5:    nxt_word = hdr_csum[15:0];
            4'd6:    nxt_word = hdr_csum[31:16];
            4'd7:    nxt_word = word_id_q;
            4'd8:    nxt_word = gen_id_q[15:0];
            4'd9:    nxt_word = gen_id_q[31:16];
            4'd10:   nxt_word = hash_num_q;
            4'd11:   nxt_word = body_csum[15:0];
            4'd12:   nxt_word = body_csum[31:16];
            default: nxt_word = 16'h0;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wcnt       <= 4'd0;
            pkt_id     <= 16'h0;
            pkt_count  <= 16'h0;
            dout       <= 16'h0;
            word_id_q  <= 16'h0;
            gen_id_q   <= 32'h0;
            hash_num_q <= 16'h0;
            hdr_csum   <= 32'h0;
            body_csum  <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (res_rd_en) begin
                        word_id_q  <= res_word_id;
                        gen_id_q   <= res_gen_id;
                        hash_num_q <= res_hash_num;
                        hdr_csum   <= hdr_csum_c;
                        body_csum  <= body_csum_c;
                        wcnt       <= 4'd0;
                        dout       <= W0;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    // dout and wcnt hold while output_fifo is full
                    if (wr_en) begin
                        if (wcnt == LAST_W) begin
                            wcnt      <= 4'd0;
                            dout      <= 16'h0;
                            pkt_id    <= pkt_id + 16'd1;
                            pkt_count <= pkt_count + 16'd1;
                            state     <= IDLE;
                        end else begin
                            wcnt <= wnext;
                            dout <= nxt_word;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_outpkt_cmp_result.sv
// Scoreboard bench for outpkt_cmp_result: a checksummed and a
// checksum-disabled instance run side by side on the same stimulus.
module tb_outpkt_cmp_result;

    typedef struct packed {
        logic [15:0] wid;
        logic [31:0] gid;
        logic [15:0] hn;
    } rec_t;

    logic        CLK;
    logic        rst_n;
    logic        res_empty;
    logic [15:0] res_word_id;
    logic [31:0] res_gen_id;
    logic [15:0] res_hash_num;
    logic        full;

    logic        res_rd_en;
    logic [15:0] dout;
    logic        wr_en;
    logic        idle;
    logic [15:0] pkt_count;

    logic        res_rd_en_n;
    logic [15:0] dout_n;
    logic        wr_en_n;
    logic        idle_n;
    logic [15:0] pkt_count_n;

    int chk_cnt;
    int pass_cnt;
    int cyc;

    rec_t        rec_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] exp2_q[$];
    logic [15:0] cap_q[$];
    logic [15:0] cap2_q[$];
    logic [15:0] exp_pkt_id;

    outpkt_cmp_result dut (
        .CLK(CLK), .rst_n(rst_n),
        .res_empty(res_empty), .res_rd_en(res_rd_en),
        .res_word_id(res_word_id), .res_gen_id(res_gen_id),
        .res_hash_num(res_hash_num),
        .dout(dout), .wr_en(wr_en), .full(full),
        .idle(idle), .pkt_count(pkt_count)
    );

    outpkt_cmp_result #(.DISABLE_CHECKSUM(1'b1)) dut_nc (
        .CLK(CLK), .rst_n(rst_n),
        .res_empty(res_empty), .res_rd_en(res_rd_en_n),
        .res_word_id(res_word_id), .res_gen_id(res_gen_id),
        .res_hash_num(res_hash_num),
        .dout(dout_n), .wr_en(wr_en_n), .full(full),
        .idle(idle_n), .pkt_count(pkt_count_n)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] csum(input logic [15:0] w[13],
                                         input int lo, input int n);
        logic [31:0] s;
        logic [15:0] hi;
        s = 32'h0;
        for (int k = 0; k < n; k += 2) begin
            hi = (k + 1 < n) ? w[lo+k+1] : 16'h0;
            s = s + {hi, w[lo+k]};
        end
        return ~s;
    endfunction

    function automatic void build(input rec_t r, input logic [15:0] pid,
                                  input bit dis, output logic [15:0] w[13]);
        logic [31:0] c;
        w[0] = 16'hD402; w[1] = 16'h0; w[2] = 16'd8;
        w[3] = 16'h0;    w[4] = pid;
        w[7] = r.wid;    w[8] = r.gid[15:0];
        w[9] = r.gid[31:16]; w[10] = r.hn;
        c = dis ? 32'h0 : csum(w, 0, 5);
        w[5] = c[15:0]; w[6] = c[31:16];
        c = dis ? 32'h0 : csum(w, 7, 4);
        w[11] = c[15:0]; w[12] = c[31:16];
    endfunction

    function automatic void refresh();
        res_empty = (rec_q.size() == 0);
        if (rec_q.size() != 0) begin
            res_word_id  = rec_q[0].wid;
            res_gen_id   = rec_q[0].gid;
            res_hash_num = rec_q[0].hn;
        end else begin
            res_word_id  = 16'hDEAD;
            res_gen_id   = 32'hDEADBEEF;
            res_hash_num = 16'hBEEF;
        end
    endfunction

    function automatic void push_rec(input rec_t r);
        logic [15:0] w[13];
        rec_q.push_back(r);
        build(r, exp_pkt_id, 1'b0, w);
        for (int i = 0; i < 13; i++) exp_q.push_back(w[i]);
        build(r, exp_pkt_id, 1'b1, w);
        for (int i = 0; i < 13; i++) exp2_q.push_back(w[i]);
        exp_pkt_id = exp_pkt_id + 16'd1;
        refresh();
    endfunction

    // result FIFO model: pop on the edge res_rd_en is seen
    always @(posedge CLK) begin
        if (rst_n && res_rd_en && rec_q.size() != 0)
            rec_q.delete(0);
        #1 refresh();
    end

    // scoreboard: every written word must be the next expected one
    always @(negedge CLK) begin
        if (rst_n) begin
            cyc++;
            chk_cnt++;
            if (res_rd_en_n !== res_rd_en)
                $display("FAIL rd_en_match got=%b want=%b", res_rd_en_n, res_rd_en);
            else pass_cnt++;
            if (wr_en) begin
                chk_cnt++;
                if (full)
                    $display("FAIL wr_while_full wr_en=1 full=%b want full=0", full);
                else pass_cnt++;
                chk_cnt++;
                if (exp_q.size() == 0)
                    $display("FAIL word_extra got=%h want=none", dout);
                else if (dout !== exp_q.pop_front())
                    $display("FAIL word got=%h cnt=%0d", dout, cap_q.size());
                else pass_cnt++;
                cap_q.push_back(dout);
            end
            if (wr_en_n) begin
                chk_cnt++;
                if (exp2_q.size() == 0)
                    $display("FAIL nc_word_extra got=%h want=none", dout_n);
                else if (dout_n !== exp2_q.pop_front())
                    $display("FAIL nc_word got=%h cnt=%0d", dout_n, cap2_q.size());
                else pass_cnt++;
                cap2_q.push_back(dout_n);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        full  = 1'b0;
        rec_q.delete();
        exp_q.delete();
        exp2_q.delete();
        cap_q.delete();
        cap2_q.delete();
        exp_pkt_id = 16'h0;
        refresh();
        repeat (3) @(posedge CLK);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input bit rnd, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || !idle) && n < budget) begin
            @(posedge CLK);
            #1;
            if (rnd) full = 1'($urandom_range(0, 1));
            n++;
        end
        full = 1'b0;
        @(negedge CLK);
        #1;
        chk_cnt++;
        if (n >= budget)
            $display("FAIL %s_timeout left=%0d want=0", tag, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        int bad = 0;
        do_reset();
        repeat (50) begin
            @(negedge CLK);
            if (res_rd_en !== 1'b0 || wr_en !== 1'b0 || idle !== 1'b1
                || idle_n !== 1'b1 || pkt_count !== 16'h0)
                bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL reset_outputs bad_cycles=%0d want=0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (dout !== 16'h0) $display("FAIL reset_dout got=%h want=0000", dout);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic [15:0] ref_w [13];
        rec_t r;
        int rd_c = -1;
        int wr_c = -1;
        int n = 0;
        ref_w = '{16'hD402, 16'h0000, 16'h0008, 16'h0000, 16'h0000,
                  16'h2BF5, 16'hFFFF, 16'h0005, 16'h5678, 16'h1234,
                  16'h0001, 16'hEDC6, 16'hA986};
        do_reset();
        r = '{wid: 16'h0005, gid: 32'h12345678, hn: 16'h0001};
        push_rec(r);
        while ((exp_q.size() != 0 || !idle || rd_c < 0) && n < 60) begin
            @(negedge CLK);
            if (res_rd_en && rd_c < 0) rd_c = n;
            if (wr_en && wr_c < 0) wr_c = n;
            n++;
        end
        #1;
        chk_cnt++;
        if (wr_c - rd_c != 1)
            $display("FAIL single_latency got=%0d want=1", wr_c - rd_c);
        else pass_cnt++;
        chk_cnt++;
        if (pkt_count !== 16'd1 || pkt_count_n !== 16'd1)
            $display("FAIL single_pkt_count got=%0d want=1", pkt_count);
        else pass_cnt++;
        chk_cnt++;
        if (cap_q.size() != 13 || cap2_q.size() != 13)
            $display("FAIL single_len got=%0d want=13", cap_q.size());
        else begin
            pass_cnt++;
            for (int i = 0; i < 13; i++) begin
                chk_cnt++;
                if (cap_q[i] !== ref_w[i])
                    $display("FAIL single_w%0d got=%h want=%h", i, cap_q[i], ref_w[i]);
                else pass_cnt++;
                if (i == 5 || i == 6 || i == 11 || i == 12) ref_w[i] = 16'h0;
                chk_cnt++;
                if (cap2_q[i] !== ref_w[i])
                    $display("FAIL nocsum_w%0d got=%h want=%h", i, cap2_q[i], ref_w[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure();
        rec_t r;
        int n = 0;
        do_reset();
        r = '{wid: 16'h0005, gid: 32'h12345678, hn: 16'h0001};
        push_rec(r);
        while (cap_q.size() < 3 && n < 40) begin
            @(negedge CLK);
            #1;
            n++;
        end
        @(posedge CLK);
        #1 full = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        wait_drain(400, 1'b1, "bp");
        chk_cnt++;
        if (cap_q.size() != 13 || pkt_count !== 16'd1)
            $display("FAIL bp_count words=%0d pkts=%0d want 13/1", cap_q.size(), pkt_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        rec_t r;
        int rd_cyc[$];
        int n = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            r = '{wid: 16'(16'h0100 + k), gid: 32'(32'hA5A50000 + k * 7),
                  hn: 16'(k + 2)};
            push_rec(r);
        end
        while ((exp_q.size() != 0 || !idle) && n < 100) begin
            @(negedge CLK);
            if (res_rd_en) rd_cyc.push_back(n);
            n++;
        end
        #1;
        chk_cnt++;
        if (rd_cyc.size() != 3)
            $display("FAIL b2b_pops got=%0d want=3", rd_cyc.size());
        else begin
            pass_cnt++;
            for (int k = 1; k < 3; k++) begin
                chk_cnt++;
                if (rd_cyc[k] - rd_cyc[k-1] != 14)
                    $display("FAIL b2b_gap got=%0d want=14", rd_cyc[k] - rd_cyc[k-1]);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (pkt_count !== 16'd3)
            $display("FAIL b2b_pkt_count got=%0d want=3", pkt_count);
        else pass_cnt++;
        chk_cnt++;
        if (cap_q.size() != 39)
            $display("FAIL b2b_len got=%0d want=39", cap_q.size());
        else begin
            pass_cnt++;
            for (int k = 0; k < 3; k++) begin
                chk_cnt++;
                if (cap_q[13*k+4] !== 16'(k))
                    $display("FAIL b2b_pkt_id got=%h want=%0d", cap_q[13*k+4], k);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_mid_reset();
        rec_t r;
        int n = 0;
        do_reset();
        r = '{wid: 16'h0005, gid: 32'h12345678, hn: 16'h0001};
        push_rec(r);
        push_rec(r);
        while (cap_q.size() < 7 && n < 40) begin
            @(negedge CLK);
            #1;
            n++;
        end
        @(posedge CLK);
        #1 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (wr_en !== 1'b0 || idle !== 1'b1 || pkt_count !== 16'h0)
            $display("FAIL midrst_abort wr_en=%b idle=%b cnt=%0d want 0/1/0",
                     wr_en, idle, pkt_count);
        else pass_cnt++;
        rec_q.delete();
        exp_q.delete();
        exp2_q.delete();
        cap_q.delete();
        cap2_q.delete();
        exp_pkt_id = 16'h0;
        refresh();
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        r = '{wid: 16'h7777, gid: 32'hCAFEF00D, hn: 16'h0003};
        push_rec(r);
        wait_drain(60, 1'b0, "midrst");
        chk_cnt++;
        if (cap_q.size() != 13 || cap_q[0] !== 16'hD402 || cap_q[4] !== 16'h0)
            $display("FAIL midrst_restart len=%0d w0=%h w4=%h want 13/D402/0000",
                     cap_q.size(), cap_q.size() > 0 ? cap_q[0] : 16'hx,
                     cap_q.size() > 4 ? cap_q[4] : 16'hx);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        full     = 1'b0;
        exp_pkt_id = 16'h0;
        refresh();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
